i2c_slave_regfile: RTL and testbench

- Second-generation I2C target: fully synchronous, oversampled from one system clock; no logic clocked by SCL or SDA.
- Parametrised 7-bit address and register-file depth.
- Master access: pointer byte, then auto-incrementing burst writes, or burst reads from the current pointer; repeated START supported.
- Fabric side has a local write port, a combinational read port and a one-cycle strobe for every I2C-written register.

---
 rtl/i2c_slave_regfile.sv | 245 ++++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C target with an auto-incrementing register file, oversampled from one system clock.
// Fabric side has a local write port, a combinational read port and a write strobe.
`timescale 1ns/1ps
module i2c_slave_regfile #(
    parameter logic [6:0] ADDRESS    = 7'b0101010,
    parameter int         NUM_REGS   = 16,
    parameter int         FILTER_LEN = 3,
    localparam int        IW         = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          busy,
    output logic          wr_strobe,
    output logic [IW-1:0] wr_idx,
    output logic [7:0]    wr_data,
    input  logic          loc_we,
    input  logic [IW-1:0] loc_idx,
    input  logic [7:0]    loc_wdata,
    output logic [7:0]    loc_rdata
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    logic [1:0]            scl_sync_r, sda_sync_r;
    logic [FILTER_LEN-1:0] scl_hist_r, sda_hist_r;
    logic                  scl_f_r, sda_f_r, scl_d_r, sda_d_r;
    logic                  rise_r, fall_r, start_r, stop_r;

    state_t          state_r, state_s;
    logic [7:0]      regs_r [NUM_REGS];
    logic [7:0]      shift_r, shift_s, rd_byte_s;
    logic [2:0]      cnt_r, cnt_s;
    logic            got8_r, got8_s, rw_r, rw_s, nack_r, nack_s;
    logic [IW-1:0]   ptr_r, ptr_s, wr_idx_s;
    logic            sda_oe_s, busy_s, wr_strobe_s, i2c_we_s;
    logic [7:0]      wr_data_s;

    assign rd_byte_s = regs_r[ptr_r];
    assign loc_rdata = regs_r[loc_idx];

    // Synchronise, glitch-filter and edge-detect both bus lines; the idle bus level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
            scl_hist_r <= {FILTER_LEN{1'b1}};
            sda_hist_r <= {FILTER_LEN{1'b1}};
            scl_f_r    <= 1'b1;
            sda_f_r    <= 1'b1;
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
            rise_r     <= 1'b0;
            fall_r     <= 1'b0;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
        end else begin
            scl_sync_r <= {scl_sync_r[0], scl_i};
            sda_sync_r <= {sda_sync_r[0], sda_i};
            scl_hist_r <= FILTER_LEN'({scl_hist_r, scl_sync_r[1]});
            sda_hist_r <= FILTER_LEN'({sda_hist_r, sda_sync_r[1]});
            if (&scl_hist_r)       scl_f_r <= 1'b1;
            else if (~|scl_hist_r) scl_f_r <= 1'b0;
            if (&sda_hist_r)       sda_f_r <= 1'b1;
            else if (~|sda_hist_r) sda_f_r <= 1'b0;
            scl_d_r <= scl_f_r;
            sda_d_r <= sda_f_r;
            rise_r  <= scl_f_r & ~scl_d_r;
            fall_r  <= ~scl_f_r & scl_d_r;
            start_r <= scl_f_r & scl_d_r & ~sda_f_r & sda_d_r;
            stop_r  <= scl_f_r & scl_d_r & sda_f_r & ~sda_d_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Next-state logic: STOP and START override every state; otherwise advance on SCL falls.
    always_comb begin
        state_s = state_r;
        if (stop_r) begin
            state_s = IDLE;
        end else if (start_r) begin
            state_s = ADDR;
        end else if (fall_r) begin
            case (state_r)
                ADDR:      state_s = !got8_r ? ADDR : ((shift_r[7:1] == ADDRESS) ? ADDR_ACK : WAIT_STOP);
                ADDR_ACK:  state_s = rw_r ? RDATA : PTR;
                PTR:       state_s = got8_r ? PTR_ACK : PTR;
                PTR_ACK:   state_s = WDATA;
                WDATA:     state_s = got8_r ? WDATA_ACK : WDATA;
                WDATA_ACK: state_s = WDATA;
                RDATA:     state_s = (cnt_r == 3'd0) ? RDATA_ACK : RDATA;
                RDATA_ACK: state_s = nack_r ? WAIT_STOP : RDATA;
                default:   state_s = state_r;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Datapath and output next values: sample SDA on rises, change SDA drive only on falls.
    always_comb begin
        shift_s     = shift_r;
        cnt_s       = cnt_r;
        got8_s      = got8_r;
        rw_s        = rw_r;
        nack_s      = nack_r;
        ptr_s       = ptr_r;
        sda_oe_s    = sda_oe;
        busy_s      = busy;
        wr_strobe_s = 1'b0;
        wr_idx_s    = wr_idx;
        wr_data_s   = wr_data;
        i2c_we_s    = 1'b0;
        if (stop_r) begin
            sda_oe_s = 1'b0;
            busy_s   = 1'b0;
            got8_s   = 1'b0;
        end else if (start_r) begin
            sda_oe_s = 1'b0;
            cnt_s    = 3'd7;
            got8_s   = 1'b0;
        end else if (rise_r) begin
            case (state_r)
                ADDR, PTR, WDATA: begin
                    shift_s = {shift_r[6:0], sda_f_r};
                    if (cnt_r == 3'd0) got8_s = 1'b1;
                    else               cnt_s  = cnt_r - 3'd1;
                end
                RDATA_ACK: nack_s = sda_f_r;
                default:   nack_s = nack_r;
            endcase
        end else if (fall_r) begin
            case (state_r)
                ADDR: if (got8_r) begin
                    got8_s = 1'b0;
                    rw_s   = shift_r[0];
                    if (shift_r[7:1] == ADDRESS) begin
                        sda_oe_s = 1'b1;
                        busy_s   = 1'b1;
                    end else begin
                        sda_oe_s = 1'b0;
                    end
                end else begin
                    sda_oe_s = 1'b0;
                end
                ADDR_ACK: begin
                    cnt_s = 3'd7;
                    if (rw_r) begin
                        shift_s  = rd_byte_s;
                        sda_oe_s = ~rd_byte_s[7];
                    end else begin
                        sda_oe_s = 1'b0;
                    end
                end
                PTR: if (got8_r) begin
                    got8_s   = 1'b0;
                    ptr_s    = shift_r[IW-1:0];
                    sda_oe_s = 1'b1;
                end else begin
                    sda_oe_s = 1'b0;
                end
                PTR_ACK, WDATA_ACK: begin
                    sda_oe_s = 1'b0;
                    cnt_s    = 3'd7;
                end
                WDATA: if (got8_r) begin
                    got8_s      = 1'b0;
                    i2c_we_s    = 1'b1;
                    wr_strobe_s = 1'b1;
                    wr_idx_s    = ptr_r;
                    wr_data_s   = shift_r;
                    ptr_s       = ptr_r + IW'(1);
                    sda_oe_s    = 1'b1;
                end else begin
                    sda_oe_s = 1'b0;
                end
                RDATA: if (cnt_r == 3'd0) begin
                    sda_oe_s = 1'b0;
                    ptr_s    = ptr_r + IW'(1);
                end else begin
                    shift_s  = {shift_r[6:0], 1'b0};
                    sda_oe_s = ~shift_r[6];
                    cnt_s    = cnt_r - 3'd1;
                end
                RDATA_ACK: if (!nack_r) begin
                    shift_s  = rd_byte_s;
                    sda_oe_s = ~rd_byte_s[7];
                    cnt_s    = 3'd7;
                end else begin
                    sda_oe_s = 1'b0;
                end
                default: sda_oe_s = 1'b0;
            endcase
        end else begin
            sda_oe_s = sda_oe;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r   <= 8'h00;
            cnt_r     <= 3'd7;
            got8_r    <= 1'b0;
            rw_r      <= 1'b0;
            nack_r    <= 1'b0;
            ptr_r     <= {IW{1'b0}};
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_idx    <= {IW{1'b0}};
            wr_data   <= 8'h00;
        end else begin
            shift_r   <= shift_s;
            cnt_r     <= cnt_s;
            got8_r    <= got8_s;
            rw_r      <= rw_s;
            nack_r    <= nack_s;
            ptr_r     <= ptr_s;
            sda_oe    <= sda_oe_s;
            busy      <= busy_s;
            wr_strobe <= wr_strobe_s;
            wr_idx    <= wr_idx_s;
            wr_data   <= wr_data_s;
        end
    end

    // Register file: the I2C write comes last so it wins a same-index collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 8'h00;
        end else begin
            if (loc_we)   regs_r[loc_idx] <= loc_wdata;
            if (i2c_we_s) regs_r[ptr_r]   <= shift_r;
        end
    end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: a bit-banged I2C master on an open-drain bus model drives i2c_slave_regfile.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;
    localparam int Q = 12;

    logic       clk = 1'b0;
    logic       rst, scl_m, sda_m, loc_we;
    logic [3:0] loc_idx, wr_idx;
    logic [7:0] loc_wdata, loc_rdata, wr_data;
    logic       sda_oe, busy, wr_strobe;
    wire        sda_bus = sda_m & ~sda_oe;

    int tests = 0, fails = 0;
    int s_cnt = 0, oe_cnt = 0, busy_cnt = 0;
    logic [3:0] s_idx [256];
    logic [7:0] s_dat [256];

    always #5 clk = ~clk;

    i2c_slave_regfile dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe), .busy(busy),
        .wr_strobe(wr_strobe), .wr_idx(wr_idx), .wr_data(wr_data), .loc_we(loc_we),
        .loc_idx(loc_idx), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata)
    );

    // Bus monitor: logs write strobes and counts cycles with SDA pulled or busy high.
    always @(negedge clk) begin
        if (wr_strobe) begin
            s_idx[s_cnt[7:0]] = wr_idx;
            s_dat[s_cnt[7:0]] = wr_data;
            s_cnt = s_cnt + 1;
        end
        if (sda_oe) oe_cnt = oe_cnt + 1;
        if (busy)   busy_cnt = busy_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reg(input string tag, input logic [3:0] idx, input logic [7:0] exp);
        loc_idx = idx;
        #1;
        check(tag, {24'h0, loc_rdata}, {24'h0, exp});
    endtask

    task automatic loc_write(input logic [3:0] idx, input logic [7:0] data);
        loc_idx = idx; loc_wdata = data; loc_we = 1'b1;
        tick(1);
        loc_we = 1'b0;
    endtask

    task automatic bit_out(input logic b, output logic line);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(Q);
        line = sda_bus; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; tick(2*Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(2*Q);
        sda_m = 1'b0; tick(2*Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(2*Q);
        sda_m = 1'b1; tick(2*Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic l;
        for (int i = 7; i >= 0; i--) bit_out(d[i], l);
        bit_out(1'b1, ack);
    endtask

    // Same as send_byte but with a 1-clock SCL pulse while low and an SDA pulse while high.
    task automatic send_byte_g(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = d[i];  tick(Q/2);
            scl_m = 1'b1;  tick(1);
            scl_m = 1'b0;  tick(Q/2 - 1);
            scl_m = 1'b1;  tick(Q/2);
            sda_m = ~d[i]; tick(1);
            sda_m = d[i];  tick(Q/2 - 1);
            scl_m = 1'b0;  tick(Q);
        end
        bit_out(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic l;
        for (int i = 7; i >= 0; i--) begin
            bit_out(1'b1, l);
            d[i] = l;
        end
        bit_out(nack, l);
    endtask

    initial begin
        logic       a;
        logic [7:0] d;
        logic       seen;
        int         base, obase, bbase;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        loc_we = 1'b0; loc_idx = 4'd0; loc_wdata = 8'h00;
        tick(4);
        check("rst sda_oe", {31'h0, sda_oe}, 32'h0);
        check("rst busy", {31'h0, busy}, 32'h0);
        check("rst wr_strobe", {31'h0, wr_strobe}, 32'h0);
        check("rst wr_idx", {28'h0, wr_idx}, 32'h0);
        check("rst wr_data", {24'h0, wr_data}, 32'h0);
        check_reg("rst reg0", 4'd0, 8'h00);
        check_reg("rst reg15", 4'd15, 8'h00);
        rst = 1'b0;
        tick(2*Q);

        // Burst write: pointer 2, data A5, 3C
        base = s_cnt;
        i2c_start();
        send_byte(8'h54, a); check("bw addr ack", {31'h0, a}, 32'h0);
        check("bw busy", {31'h0, busy}, 32'h1);
        send_byte(8'h02, a); check("bw ptr ack", {31'h0, a}, 32'h0);
        send_byte(8'hA5, a); check("bw d0 ack", {31'h0, a}, 32'h0);
        send_byte(8'h3C, a); check("bw d1 ack", {31'h0, a}, 32'h0);
        i2c_stop();
        tick(Q);
        check("bw busy after stop", {31'h0, busy}, 32'h0);
        check("bw strobes", s_cnt - base, 32'd2);
        check("bw strobe0 idx", {28'h0, s_idx[base]}, 32'h2);
        check("bw strobe0 data", {24'h0, s_dat[base]}, 32'hA5);
        check("bw strobe1 idx", {28'h0, s_idx[base+1]}, 32'h3);
        check("bw strobe1 data", {24'h0, s_dat[base+1]}, 32'h3C);
        check_reg("bw reg2", 4'd2, 8'hA5);
        check_reg("bw reg3", 4'd3, 8'h3C);

        // Combined read with repeated START, then pointer persistence (4)
        loc_write(4'd4, 8'h4D);
        base = s_cnt;
        i2c_start();
        send_byte(8'h54, a); check("cr addr ack", {31'h0, a}, 32'h0);
        send_byte(8'h02, a); check("cr ptr ack", {31'h0, a}, 32'h0);
        i2c_rstart();
        send_byte(8'h55, a); check("cr raddr ack", {31'h0, a}, 32'h0);
        read_byte(1'b0, d); check("cr byte0", {24'h0, d}, 32'hA5);
        read_byte(1'b1, d); check("cr byte1", {24'h0, d}, 32'h3C);
        check("cr release after nack", {31'h0, sda_oe}, 32'h0);
        i2c_stop();
        i2c_start();
        send_byte(8'h55, a); check("cr2 addr ack", {31'h0, a}, 32'h0);
        read_byte(1'b1, d); check("cr2 ptr=4 byte", {24'h0, d}, 32'h4D);
        i2c_stop();
        check("cr no strobes", s_cnt - base, 32'd0);

        // Pointer wrap 15 -> 0
        base = s_cnt;
        i2c_start();
        send_byte(8'h54, a); check("wr addr ack", {31'h0, a}, 32'h0);
        send_byte(8'h0F, a); check("wr ptr ack", {31'h0, a}, 32'h0);
        send_byte(8'h11, a); check("wr d0 ack", {31'h0, a}, 32'h0);
        send_byte(8'h22, a); check("wr d1 ack", {31'h0, a}, 32'h0);
        i2c_stop();
        check_reg("wr reg15", 4'd15, 8'h11);
        check_reg("wr reg0", 4'd0, 8'h22);
        check("wr strobe0 idx", {28'h0, s_idx[base]}, 32'hF);
        check("wr strobe1 idx", {28'h0, s_idx[base+1]}, 32'h0);

        // Address mismatch: no ACK, no busy, no strobes
        base = s_cnt; obase = oe_cnt; bbase = busy_cnt;
        i2c_start();
        send_byte(8'h56, a); check("mm addr nack", {31'h0, a}, 32'h1);
        send_byte(8'hA5, a); check("mm data nack", {31'h0, a}, 32'h1);
        i2c_stop();
        check("mm sda_oe cycles", oe_cnt - obase, 32'd0);
        check("mm busy cycles", busy_cnt - bbase, 32'd0);
        check("mm strobes", s_cnt - base, 32'd0);

        // Glitch rejection on an idle bus and mid-byte
        sda_m = 1'b0; tick(1); sda_m = 1'b1; tick(2*Q);
        scl_m = 1'b0; tick(1); scl_m = 1'b1; tick(2*Q);
        check("gl idle busy", {31'h0, busy}, 32'h0);
        base = s_cnt;
        i2c_start();
        send_byte(8'h54, a); check("gl addr ack", {31'h0, a}, 32'h0);
        send_byte(8'h07, a); check("gl ptr ack", {31'h0, a}, 32'h0);
        send_byte_g(8'h5A, a); check("gl data ack", {31'h0, a}, 32'h0);
        check("gl busy mid", {31'h0, busy}, 32'h1);
        i2c_stop();
        check_reg("gl reg7", 4'd7, 8'h5A);
        check("gl strobes", s_cnt - base, 32'd1);
        check("gl strobe data", {24'h0, s_dat[base]}, 32'h5A);

        // Collision: local write to index 5 held until the I2C write strobe appears
        i2c_start();
        send_byte(8'h54, a); check("co addr ack", {31'h0, a}, 32'h0);
        send_byte(8'h05, a); check("co ptr ack", {31'h0, a}, 32'h0);
        seen = 1'b0;
        fork
            send_byte(8'h77, a);
            begin
                loc_idx = 4'd5; loc_wdata = 8'h99; loc_we = 1'b1;
                for (int k = 0; k < 2000 && !seen; k++) begin
                    @(negedge clk);
                    if (wr_strobe) seen = 1'b1;
                end
                loc_we = 1'b0;
            end
        join
        check("co strobe seen", {31'h0, seen}, 32'h1);
        check("co data ack", {31'h0, a}, 32'h0);
        i2c_stop();
        check_reg("co reg5", 4'd5, 8'h77);

        // Reset while the slave drives a 0 data bit
        loc_write(4'd8, 8'h12);
        i2c_start();
        send_byte(8'h54, a); check("rr addr ack", {31'h0, a}, 32'h0);
        send_byte(8'h08, a); check("rr ptr ack", {31'h0, a}, 32'h0);
        i2c_rstart();
        send_byte(8'h55, a); check("rr raddr ack", {31'h0, a}, 32'h0);
        check("rr driving msb 0", {31'h0, sda_oe}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rr sda_oe after rst", {31'h0, sda_oe}, 32'h0);
        check("rr busy after rst", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        check_reg("rr reg8 cleared", 4'd8, 8'h00);
        check_reg("rr reg2 cleared", 4'd2, 8'h00);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(2*Q);
        loc_write(4'd0, 8'hC3);
        i2c_start();
        send_byte(8'h55, a); check("rr2 addr ack", {31'h0, a}, 32'h0);
        read_byte(1'b1, d); check("rr2 ptr cleared", {24'h0, d}, 32'hC3);
        i2c_stop();
        i2c_start();
        send_byte(8'h54, a); check("rr3 addr ack", {31'h0, a}, 32'h0);
        send_byte(8'h01, a); check("rr3 ptr ack", {31'h0, a}, 32'h0);
        send_byte(8'h66, a); check("rr3 data ack", {31'h0, a}, 32'h0);
        i2c_stop();
        check_reg("rr3 reg1", 4'd1, 8'h66);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
